axi4l_to_core: RTL and testbench

//  AXI4-Lite slave to Ibex-style core memory-bus (req/gnt/rvalid) master bridge.

---
 rtl/axi4l_to_core_pkg.sv | 19 +
 rtl/axi4l_to_core_if.sv | 41 ++++
 rtl/axi4l_to_core.sv | 136 +++++++++++++
 tb/tb_axi4l_to_core.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_to_core_pkg.sv
// Shared types for the AXI4-Lite to core-bus bridge: response codes and default widths.
package axi4l_to_core_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // The core bus only reports pass/fail, so EXOKAY and DECERR never occur.
  function automatic resp_t err_to_resp(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axi4l_to_core_if.sv
// AXI4-Lite bus bundle; the bridge sits on the slave modport.
// Handshake: a beat transfers on a cycle where valid && ready; valid, once raised,
// holds with its payload stable until that cycle, and ready may depend on valid.
interface axi4l_to_core_if #(
  parameter int AW = axi4l_to_core_pkg::AW_DEFAULT,
  parameter int DW = axi4l_to_core_pkg::DW_DEFAULT
);

  logic                      awvalid;
  logic                      awready;
  logic [AW-1:0]             awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DW-1:0]             wdata;
  logic [DW/8-1:0]           wstrb;
  logic                      bvalid;
  logic                      bready;
  axi4l_to_core_pkg::resp_t  bresp;
  logic                      arvalid;
  logic                      arready;
  logic [AW-1:0]             araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DW-1:0]             rdata;
  axi4l_to_core_pkg::resp_t  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4l_to_core.sv
// AXI4-Lite slave to req/gnt/rvalid core-bus master, one transaction in flight.
// Core request fields are decoded straight from the held AXI payload.
module axi4l_to_core
  import axi4l_to_core_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  axi4l_to_core_if.slave  axi,
  output logic            req_o,
  input  logic            gnt_i,
  output logic            we_o,
  output logic [DW/8-1:0] be_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  input  logic            rvalid_i,
  input  logic [DW-1:0]   rdata_i,
  input  logic            err_i,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_READ        = 3'd1,
    S_READ_WAIT0  = 3'd2,
    S_READ_WAIT1  = 3'd3,
    S_WRITE       = 3'd4,
    S_WRITE_WAIT0 = 3'd5,
    S_WRITE_WAIT1 = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  resp_t         rresp_q, rresp_d;
  resp_t         bresp_q, bresp_d;

  logic unused_prot;
  assign unused_prot = ^{axi.awprot, axi.arprot};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      rresp_q <= OKAY;
      bresp_q <= OKAY;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    bresp_d     = bresp_q;
    req_o       = 1'b0;
    we_o        = 1'b0;
    be_o        = '0;
    addr_o      = '0;
    wdata_o     = '0;
    axi.arready = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.rvalid  = 1'b0;
    axi.bvalid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Reads win ties; a write needs both address and data present.
        if (axi.arvalid) begin
          state_d = S_READ;
        end else if (axi.awvalid && axi.wvalid) begin
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        req_o  = 1'b1;
        be_o   = '1;
        addr_o = axi.araddr;
        if (gnt_i) begin
          axi.arready = 1'b1;
          state_d     = S_READ_WAIT0;
        end
      end
      S_READ_WAIT0: begin
        if (rvalid_i) begin
          rdata_d = rdata_i;
          rresp_d = err_to_resp(err_i);
          state_d = S_READ_WAIT1;
        end
      end
      S_READ_WAIT1: begin
        axi.rvalid = 1'b1;
        if (axi.rready) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        be_o    = axi.wstrb;
        addr_o  = axi.awaddr;
        wdata_o = axi.wdata;
        if (gnt_i) begin
          axi.awready = 1'b1;
          axi.wready  = 1'b1;
          state_d     = S_WRITE_WAIT0;
        end
      end
      S_WRITE_WAIT0: begin
        if (rvalid_i) begin
          bresp_d = err_to_resp(err_i);
          state_d = S_WRITE_WAIT1;
        end
      end
      S_WRITE_WAIT1: begin
        axi.bvalid = 1'b1;
        if (axi.bready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign axi.rdata = rdata_q;
  assign axi.rresp = rresp_q;
  assign axi.bresp = bresp_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_axi4l_to_core.sv
// Directed bench for axi4l_to_core: AXI master and core-bus slave driven step by step.
module tb_axi4l_to_core;
  import axi4l_to_core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_o, gnt_i, we_o, rvalid_i, err_i;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic [2:0]  state_o;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  axi4l_to_core_if #(.AW(32), .DW(32)) bus ();

  axi4l_to_core #(.AW(32), .DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axi      (bus.slave),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .we_o     (we_o),
    .be_o     (be_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .err_i    (err_i),
    .state_o  (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input int gnt_dly, input logic [31:0] d,
                          input logic e, input logic [1:0] exp_resp, input int rr_dly);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    #1;
    check("rd_idle_arready", bus.arready, 0);
    step();
    for (int i = 0; i < gnt_dly; i++) begin
      check("rd_req_held", req_o, 1);
      check("rd_addr_held", addr_o, a);
      check("rd_arready_wait", bus.arready, 0);
      step();
    end
    gnt_i = 1'b1;
    #1;
    check("rd_state", state_o, 1);
    check("rd_req", req_o, 1);
    check("rd_we", we_o, 0);
    check("rd_be", be_o, 4'hF);
    check("rd_addr", addr_o, a);
    check("rd_arready", bus.arready, 1);
    check("rd_awready", bus.awready, 0);
    step();
    bus.arvalid = 1'b0;
    gnt_i       = 1'b0;
    #1;
    check("rd_wait0_state", state_o, 2);
    check("rd_wait0_req", req_o, 0);
    check("rd_wait0_rvalid", bus.rvalid, 0);
    rvalid_i = 1'b1;
    rdata_i  = d;
    err_i    = e;
    step();
    rvalid_i = 1'b0;
    rdata_i  = 32'hFFFF_FFFF;
    err_i    = ~e;
    for (int i = 0; i < rr_dly; i++) begin
      check("rd_hold_rvalid", bus.rvalid, 1);
      check("rd_hold_rdata", bus.rdata, d);
      check("rd_hold_rresp", bus.rresp, exp_resp);
      step();
    end
    bus.rready = 1'b1;
    #1;
    check("rd_rvalid", bus.rvalid, 1);
    check("rd_rdata", bus.rdata, d);
    check("rd_rresp", bus.rresp, exp_resp);
    step();
    bus.rready = 1'b0;
    err_i      = 1'b0;
    check("rd_done_state", state_o, 0);
    check("rd_done_rvalid", bus.rvalid, 0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                           input int gnt_dly, input logic e, input logic [1:0] exp_resp,
                           input int br_dly);
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    bus.wvalid  = 1'b1;
    bus.wdata   = d;
    bus.wstrb   = strb;
    #1;
    check("wr_idle_state", state_o, 0);
    check("wr_idle_awready", bus.awready, 0);
    step();
    for (int i = 0; i < gnt_dly; i++) begin
      check("wr_req_held", req_o, 1);
      check("wr_be_held", be_o, strb);
      check("wr_addr_held", addr_o, a);
      check("wr_awready_wait", bus.awready, 0);
      step();
    end
    gnt_i = 1'b1;
    #1;
    check("wr_state", state_o, 4);
    check("wr_req", req_o, 1);
    check("wr_we", we_o, 1);
    check("wr_be", be_o, strb);
    check("wr_addr", addr_o, a);
    check("wr_wdata", wdata_o, d);
    check("wr_awready", bus.awready, 1);
    check("wr_wready", bus.wready, 1);
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    gnt_i       = 1'b0;
    #1;
    check("wr_wait0_state", state_o, 5);
    check("wr_wait0_req", req_o, 0);
    check("wr_wait0_bvalid", bus.bvalid, 0);
    rvalid_i = 1'b1;
    err_i    = e;
    step();
    rvalid_i = 1'b0;
    err_i    = ~e;
    for (int i = 0; i < br_dly; i++) begin
      check("wr_hold_bvalid", bus.bvalid, 1);
      check("wr_hold_bresp", bus.bresp, exp_resp);
      step();
    end
    bus.bready = 1'b1;
    #1;
    check("wr_bvalid", bus.bvalid, 1);
    check("wr_bresp", bus.bresp, exp_resp);
    step();
    bus.bready = 1'b0;
    err_i      = 1'b0;
    check("wr_done_state", state_o, 0);
    check("wr_done_bvalid", bus.bvalid, 0);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    gnt_i       = 1'b0;
    rvalid_i    = 1'b0;
    rdata_i     = '0;
    err_i       = 1'b0;
    bus.awvalid = 1'b0;
    bus.awaddr  = '0;
    bus.awprot  = '0;
    bus.wvalid  = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.rready  = 1'b0;

    step();
    step();
    check("rst_state", state_o, 0);
    check("rst_req", req_o, 0);
    check("rst_ready", {bus.awready, bus.wready, bus.arready}, 0);
    check("rst_valid", {bus.bvalid, bus.rvalid}, 0);
    check("rst_resp", {bus.bresp, bus.rresp}, 0);
    check("rst_rdata", bus.rdata, 0);
    rst_n = 1'b1;
    step();

    // read with same-cycle grant, then a write with late grant
    axi_read(32'h10, 0, 32'hCAFE_BABE, 1'b0, 2'b00, 0);
    axi_write(32'h20, 32'h1234_5678, 4'h3, 3, 1'b0, 2'b00, 0);

    // core errors map to SLVERR; slow rready/bready holds the response
    axi_read(32'h30, 1, 32'h0BAD_F00D, 1'b1, 2'b10, 4);
    axi_write(32'h40, 32'h8765_4321, 4'hC, 0, 1'b1, 2'b10, 4);

    // address without data is not accepted
    bus.awvalid = 1'b1;
    bus.awaddr  = 32'h50;
    for (int i = 0; i < 3; i++) begin
      step();
      check("aw_only_state", state_o, 0);
      check("aw_only_awready", bus.awready, 0);
      check("aw_only_req", req_o, 0);
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b1;
    step();
    check("w_only_state", state_o, 0);
    check("w_only_wready", bus.wready, 0);
    bus.wvalid = 1'b0;

    // stray core grant / response in IDLE
    gnt_i    = 1'b1;
    rvalid_i = 1'b1;
    err_i    = 1'b1;
    step();
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    err_i    = 1'b0;
    #1;
    check("stray_state", state_o, 0);
    check("stray_valid", {bus.bvalid, bus.rvalid}, 0);

    // read and write offered together: read first
    bus.awvalid = 1'b1;
    bus.awaddr  = 32'h60;
    bus.wvalid  = 1'b1;
    bus.wdata   = 32'h0000_00AA;
    bus.wstrb   = 4'h1;
    axi_read(32'h64, 0, 32'h1111_2222, 1'b0, 2'b00, 1);
    axi_write(32'h60, 32'h0000_00AA, 4'h1, 0, 1'b0, 2'b00, 0);

    // back-to-back traffic
    for (int i = 0; i < 5; i++) begin
      axi_read(32'h100 + 32'(i * 4), i % 3, 32'h5A5A_0000 + 32'(i), 1'b0, 2'b00, i % 2);
      axi_write(32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(15 - i), i % 2, 1'b0, 2'b00,
                i % 3);
    end

    // reset while waiting for the core read response
    bus.arvalid = 1'b1;
    bus.araddr  = 32'h70;
    step();
    gnt_i = 1'b1;
    step();
    bus.arvalid = 1'b0;
    gnt_i       = 1'b0;
    #1;
    check("mid_rst_pre_state", state_o, 2);
    rst_n = 1'b0;
    step();
    check("mid_rst_state", state_o, 0);
    check("mid_rst_req", req_o, 0);
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    rst_n    = 1'b1;
    rvalid_i = 1'b1;
    rdata_i  = 32'hDEAD_BEEF;
    step();
    rvalid_i = 1'b0;
    step();
    check("late_rsp_state", state_o, 0);
    check("late_rsp_rvalid", bus.rvalid, 0);
    check("late_rsp_rdata", bus.rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
